id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus EX-side operand select for the 5-stage RISC-V core.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/fwd_unit.sv | 35 +++
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage RISC-V core pipeline blocks.
//   XLEN / REG_AW   : datapath and register-address widths
//   Alu*            : 4-bit ALU control codes
//   Ctrl*           : bit positions inside the 4-bit {regwrite, memread, memwrite, memtoreg} bundle
//   fwd_sel_e       : operand-forwarding select
//   reg_match()     : register-address compare where x0 never matches
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;

  localparam int unsigned CtrlRegWrite = 3;
  localparam int unsigned CtrlMemRead  = 2;
  localparam int unsigned CtrlMemWrite = 1;
  localparam int unsigned CtrlMemToReg = 0;

  typedef enum logic [1:0] {
    FwdReg   = 2'b00,
    FwdExMem = 2'b01,
    FwdMemWb = 2'b10
  } fwd_sel_e;

  // x0 is hard-wired zero, so it can never be the subject of a dependency.
  function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for the two EX-stage source operands.
//   ex_rs1_i/ex_rs2_i        : source registers of the instruction now in EX
//   ex_mem_rd_i/_regwr_i     : destination of the instruction in MEM
//   mem_wb_rd_i/_regwr_i     : destination of the instruction in WB
//   sel1_o/sel2_o            : per-operand select; the younger MEM producer wins over WB
module fwd_unit
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] ex_rs1_i,
  input  logic [REG_AW-1:0] ex_rs2_i,
  input  logic [REG_AW-1:0] ex_mem_rd_i,
  input  logic              ex_mem_regwr_i,
  input  logic [REG_AW-1:0] mem_wb_rd_i,
  input  logic              mem_wb_regwr_i,
  output fwd_sel_e          sel1_o,
  output fwd_sel_e          sel2_o
);

  function automatic fwd_sel_e pick(input logic [REG_AW-1:0] rs,
                                    input logic [REG_AW-1:0] mem_rd, input logic mem_wr,
                                    input logic [REG_AW-1:0] wb_rd, input logic wb_wr);
    if (mem_wr && reg_match(mem_rd, rs)) begin
      return FwdExMem;
    end else if (wb_wr && reg_match(wb_rd, rs)) begin
      return FwdMemWb;
    end
    return FwdReg;
  endfunction

  always_comb begin
    sel1_o = pick(ex_rs1_i, ex_mem_rd_i, ex_mem_regwr_i, mem_wb_rd_i, mem_wb_regwr_i);
    sel2_o = pick(ex_rs2_i, ex_mem_rd_i, ex_mem_regwr_i, mem_wb_rd_i, mem_wb_regwr_i);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection and EX-side operand select.
// Build option: define ID_EX_FWD_EN to add the forwarding muxes (only load-use then stalls);
// without it, any RAW dependency on EX or MEM stalls until the producer reaches WB.
// Ports:
//   clk_i, rst_i (async, active-low), flush_i (squash the instruction entering EX)
//   id_*            : decoded fields from ID (rs1/rs2/rd, rf data, imm, alusrc, aluctrl, ctrl)
//   ex_mem_*        : rd/regwrite/result of the instruction in MEM
//   mem_wb_*        : rd/regwrite/writeback data of the instruction in WB
//   stall_o         : hold PC and IF/ID this cycle
//   data1_o/data2_o/ALUCtrl_o : ALU operands and control
//   store_data_o    : forwarded rs2 for stores
//   ex_rd_o/ex_ctrl_o : passed on to EX/MEM (ctrl is 0 for a bubble)
//   bubble_cnt_o    : saturating count of hazard bubbles
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic              id_alusrc_i,
  input  logic [3:0]        id_aluctrl_i,
  input  logic [3:0]        id_ctrl_i,
  input  logic [REG_AW-1:0] ex_mem_rd_i,
  input  logic              ex_mem_regwr_i,
  input  logic [XLEN-1:0]   ex_mem_data_i,
  input  logic [REG_AW-1:0] mem_wb_rd_i,
  input  logic              mem_wb_regwr_i,
  input  logic [XLEN-1:0]   mem_wb_data_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   data1_o,
  output logic [XLEN-1:0]   data2_o,
  output logic [3:0]        ALUCtrl_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [3:0]        ex_ctrl_o,
  output logic [15:0]       bubble_cnt_o
);

  logic [3:0]        ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [3:0]        aluctrl_q, aluctrl_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic              alusrc_q, alusrc_d;
  logic [15:0]       bubble_cnt_q, bubble_cnt_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic              hazard;
  logic              id_uses_ex_rd;
  logic [XLEN-1:0]   op1, rs2_fwd;

  assign id_uses_ex_rd = reg_match(rd_q, id_rs1_i) | reg_match(rd_q, id_rs2_i);

`ifdef ID_EX_FWD_EN
  fwd_sel_e sel1, sel2;

  fwd_unit u_fwd_unit (
    .ex_rs1_i       (rs1_q),
    .ex_rs2_i       (rs2_q),
    .ex_mem_rd_i    (ex_mem_rd_i),
    .ex_mem_regwr_i (ex_mem_regwr_i),
    .mem_wb_rd_i    (mem_wb_rd_i),
    .mem_wb_regwr_i (mem_wb_regwr_i),
    .sel1_o         (sel1),
    .sel2_o         (sel2)
  );

  // Only a load in EX cannot be forwarded in time.
  assign hazard = ctrl_q[CtrlMemRead] & id_uses_ex_rd;

  always_comb begin
    op1 = rs1_data_q;
    case (sel1)
      FwdExMem: op1 = ex_mem_data_i;
      FwdMemWb: op1 = mem_wb_data_i;
      default:  op1 = rs1_data_q;
    endcase
    rs2_fwd = rs2_data_q;
    case (sel2)
      FwdExMem: rs2_fwd = ex_mem_data_i;
      FwdMemWb: rs2_fwd = mem_wb_data_i;
      default:  rs2_fwd = rs2_data_q;
    endcase
  end
`else
  logic unused_fwd_inputs;

  // WB is not checked: the register file writes before it is read.
  assign hazard = (ctrl_q[CtrlRegWrite] & id_uses_ex_rd) |
                  (ex_mem_regwr_i & (reg_match(ex_mem_rd_i, id_rs1_i) |
                                     reg_match(ex_mem_rd_i, id_rs2_i)));

  assign op1     = rs1_data_q;
  assign rs2_fwd = rs2_data_q;

  assign unused_fwd_inputs = ^{ex_mem_data_i, mem_wb_rd_i, mem_wb_regwr_i, mem_wb_data_i,
                               rs1_q, rs2_q};
`endif

  // Gated by reset so an asserted reset drops a stall held up by the MEM inputs.
  assign stall_o = hazard & ~flush_i & rst_i;

  always_comb begin
    ctrl_d       = id_ctrl_i;
    rd_d         = id_rd_i;
    aluctrl_d    = id_aluctrl_i;
    rs1_data_d   = id_rs1_data_i;
    rs2_data_d   = id_rs2_data_i;
    imm_d        = id_imm_i;
    alusrc_d     = id_alusrc_i;
    rs1_d        = id_rs1_i;
    rs2_d        = id_rs2_i;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i || hazard) begin
      ctrl_d     = '0;
      rd_d       = '0;
      aluctrl_d  = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      alusrc_d   = 1'b0;
      rs1_d      = '0;
      rs2_d      = '0;
    end
    // A flush takes priority, so a squashed hazard is not counted.
    if (hazard && !flush_i && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q       <= '0;
      rd_q         <= '0;
      aluctrl_q    <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      alusrc_q     <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      rd_q         <= rd_d;
      aluctrl_q    <= aluctrl_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      alusrc_q     <= alusrc_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign data1_o      = op1;
  assign data2_o      = alusrc_q ? imm_q : rs2_fwd;
  assign store_data_o = rs2_fwd;
  assign ALUCtrl_o    = aluctrl_q;
  assign ex_rd_o      = rd_q;
  assign ex_ctrl_o    = ctrl_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-cycle capture/flush behaviour,
// then hand-written sequences for hazards, forwarding, saturation and reset mid-stall.
// Expectations follow the build option ID_EX_FWD_EN.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [XLEN-1:0]   id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic              id_alusrc_i;
  logic [3:0]        id_aluctrl_i, id_ctrl_i;
  logic [REG_AW-1:0] ex_mem_rd_i, mem_wb_rd_i;
  logic              ex_mem_regwr_i, mem_wb_regwr_i;
  logic [XLEN-1:0]   ex_mem_data_i, mem_wb_data_i;
  logic              stall_o;
  logic [XLEN-1:0]   data1_o, data2_o, store_data_o;
  logic [3:0]        ALUCtrl_o, ex_ctrl_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic [15:0]       bubble_cnt_o;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_rd_i        (id_rd_i),
    .id_rs1_data_i  (id_rs1_data_i),
    .id_rs2_data_i  (id_rs2_data_i),
    .id_imm_i       (id_imm_i),
    .id_alusrc_i    (id_alusrc_i),
    .id_aluctrl_i   (id_aluctrl_i),
    .id_ctrl_i      (id_ctrl_i),
    .ex_mem_rd_i    (ex_mem_rd_i),
    .ex_mem_regwr_i (ex_mem_regwr_i),
    .ex_mem_data_i  (ex_mem_data_i),
    .mem_wb_rd_i    (mem_wb_rd_i),
    .mem_wb_regwr_i (mem_wb_regwr_i),
    .mem_wb_data_i  (mem_wb_data_i),
    .stall_o        (stall_o),
    .data1_o        (data1_o),
    .data2_o        (data2_o),
    .ALUCtrl_o      (ALUCtrl_o),
    .store_data_o   (store_data_o),
    .ex_rd_o        (ex_rd_o),
    .ex_ctrl_o      (ex_ctrl_o),
    .bubble_cnt_o   (bubble_cnt_o)
  );

  typedef struct {
    logic              flush;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   d1, d2, imm;
    logic              alusrc;
    logic [3:0]        aluc, ctrl;
    logic              e_stall;
    logic [XLEN-1:0]   e_d1, e_d2, e_sd;
    logic [3:0]        e_aluc;
    logic [REG_AW-1:0] e_rd;
    logic [3:0]        e_ctrl;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic fl, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] im, input logic asrc, input logic [3:0] ac,
                              input logic [3:0] ct, input logic est, input logic [31:0] ed1,
                              input logic [31:0] ed2, input logic [31:0] esd,
                              input logic [3:0] eac, input logic [4:0] erd,
                              input logic [3:0] ect);
    vec_t v;
    v.flush = fl; v.rs1 = s1; v.rs2 = s2; v.rd = d; v.d1 = v1; v.d2 = v2; v.imm = im;
    v.alusrc = asrc; v.aluc = ac; v.ctrl = ct; v.e_stall = est; v.e_d1 = ed1; v.e_d2 = ed2;
    v.e_sd = esd; v.e_aluc = eac; v.e_rd = erd; v.e_ctrl = ect;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] im,
                        input logic asrc, input logic [3:0] ac, input logic [3:0] ct);
    id_rs1_i = s1; id_rs2_i = s2; id_rd_i = d; id_rs1_data_i = v1; id_rs2_data_i = v2;
    id_imm_i = im; id_alusrc_i = asrc; id_aluctrl_i = ac; id_ctrl_i = ct;
  endtask

  task automatic set_em(input logic [4:0] d, input logic wr, input logic [31:0] v);
    ex_mem_rd_i = d; ex_mem_regwr_i = wr; ex_mem_data_i = v;
  endtask

  task automatic set_wb(input logic [4:0] d, input logic wr, input logic [31:0] v);
    mem_wb_rd_i = d; mem_wb_regwr_i = wr; mem_wb_data_i = v;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vecs[0] = mk(0, 1, 2, 3, 5, 7, 0, 0, AluAdd, 4'b1000, 0, 5, 7, 7, AluAdd, 3, 4'b1000);
    vecs[1] = mk(0, 9, 0, 8, 11, 0, 100, 1, AluAdd, 4'b1000, 0, 11, 100, 0, AluAdd, 8, 4'b1000);
    vecs[2] = mk(0, 11, 12, 10, 20, 6, 0, 0, AluSub, 4'b1000, 0, 20, 6, 6, AluSub, 10, 4'b1000);
    vecs[3] = mk(0, 14, 15, 13, 32'hFF00, 32'h0F0F, 0, 0, AluAnd, 4'b1000, 0,
                 32'hFF00, 32'h0F0F, 32'h0F0F, AluAnd, 13, 4'b1000);
    vecs[4] = mk(1, 17, 18, 16, 10, 5, 0, 0, AluOr, 4'b1000, 0, 0, 0, 0, 4'b0000, 0, 4'b0000);
    vecs[5] = mk(0, 17, 18, 16, 10, 5, 0, 0, AluOr, 4'b1000, 0, 10, 5, 5, AluOr, 16, 4'b1000);
    vecs[6] = mk(0, 20, 19, 0, 300, 444, 8, 1, AluAdd, 4'b0010, 0, 300, 8, 444, AluAdd, 0,
                 4'b0010);
    vecs[7] = mk(0, 21, 22, 0, 1, 2, 0, 0, AluAdd, 4'b1000, 0, 1, 2, 2, AluAdd, 0, 4'b1000);
    vecs[8] = mk(0, 0, 0, 23, 0, 0, 0, 0, AluAdd, 4'b1000, 0, 0, 0, 0, AluAdd, 23, 4'b1000);
    vecs[9] = mk(0, 1, 0, 5, 5, 0, 4, 1, AluAdd, 4'b1101, 0, 5, 4, 0, AluAdd, 5, 4'b1101);

    rst_i = 1'b0;
    flush_i = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    set_em(0, 0, 0);
    set_wb(0, 0, 0);
    #1;
    chk("reset.stall", {31'd0, stall_o}, 0);
    chk("reset.ctrl", {28'd0, ex_ctrl_o}, 0);
    chk("reset.aluctrl", {28'd0, ALUCtrl_o}, 0);
    chk("reset.data1", data1_o, 0);
    chk("reset.data2", data2_o, 0);
    chk("reset.cnt", {16'd0, bubble_cnt_o}, 0);
    step();
    step();
    rst_i = 1'b1;

    for (int i = 0; i < 10; i++) begin
      flush_i = vecs[i].flush;
      set_id(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2, vecs[i].imm,
             vecs[i].alusrc, vecs[i].aluc, vecs[i].ctrl);
      #1;
      chk($sformatf("vec%0d.stall", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
      step();
      chk($sformatf("vec%0d.data1", i), data1_o, vecs[i].e_d1);
      chk($sformatf("vec%0d.data2", i), data2_o, vecs[i].e_d2);
      chk($sformatf("vec%0d.store", i), store_data_o, vecs[i].e_sd);
      chk($sformatf("vec%0d.aluctrl", i), {28'd0, ALUCtrl_o}, {28'd0, vecs[i].e_aluc});
      chk($sformatf("vec%0d.rd", i), {27'd0, ex_rd_o}, {27'd0, vecs[i].e_rd});
      chk($sformatf("vec%0d.ctrl", i), {28'd0, ex_ctrl_o}, {28'd0, vecs[i].e_ctrl});
      chk($sformatf("vec%0d.cnt", i), {16'd0, bubble_cnt_o}, {16'd0, exp_cnt});
    end
    flush_i = 1'b0;

    // lw x5 in EX, add x6,x5,x1 in ID.
    set_id(5, 1, 6, 0, 5, 0, 0, AluAdd, 4'b1000);
    #1;
    chk("lu.stall1", {31'd0, stall_o}, 1);
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("lu.bubble_ctrl", {28'd0, ex_ctrl_o}, 0);
    chk("lu.bubble_rd", {27'd0, ex_rd_o}, 0);
    chk("lu.cnt1", {16'd0, bubble_cnt_o}, {16'd0, exp_cnt});
    set_em(5, 1, 32'h1004);
    #1;
`ifdef ID_EX_FWD_EN
    chk("lu.stall2", {31'd0, stall_o}, 0);
    step();
    set_em(0, 0, 0);
    set_wb(5, 1, 77);
    #1;
    chk("lu.fwd_wb", data1_o, 77);
`else
    chk("lu.stall2", {31'd0, stall_o}, 1);
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("lu.cnt2", {16'd0, bubble_cnt_o}, {16'd0, exp_cnt});
    set_em(0, 0, 0);
    set_wb(5, 1, 77);
    id_rs1_data_i = 77;
    #1;
    chk("lu.stall3", {31'd0, stall_o}, 0);
    step();
    chk("lu.data1", data1_o, 77);
`endif
    chk("lu.data2", data2_o, 5);
    chk("lu.ctrl", {28'd0, ex_ctrl_o}, 4'b1000);
    chk("lu.rd", {27'd0, ex_rd_o}, 6);
    chk("lu.cnt_final", {16'd0, bubble_cnt_o}, {16'd0, exp_cnt});
    set_wb(0, 0, 0);

`ifdef ID_EX_FWD_EN
    // add x6 in EX; sub x4,x6,x1 needs x6 forwarded, MEM beats WB.
    set_id(6, 1, 4, 0, 5, 0, 0, AluSub, 4'b1000);
    #1;
    chk("fwd.stall", {31'd0, stall_o}, 0);
    step();
    set_em(6, 1, 12);
    set_wb(6, 1, 99);
    #1;
    chk("fwd.mem_wins", data1_o, 12);
    chk("fwd.rs2_reg", data2_o, 5);
    set_em(0, 0, 0);
    #1;
    chk("fwd.wb", data1_o, 99);
    set_wb(6, 0, 99);
    #1;
    chk("fwd.no_regwr", data1_o, 0);
    set_wb(0, 0, 0);
    set_id(0, 0, 9, 0, 0, 0, 0, AluAdd, 4'b1000);
    step();
    set_em(0, 1, 55);
    set_wb(0, 1, 66);
    #1;
    chk("fwd.x0_op1", data1_o, 0);
    chk("fwd.x0_store", store_data_o, 0);
    set_em(0, 0, 0);
    set_wb(0, 0, 0);
`else
    // add x3 then or x7,x3,x3: two bubbles until add reaches WB.
    set_id(1, 2, 3, 5, 7, 0, 0, AluAdd, 4'b1000);
    #1;
    chk("raw.stall0", {31'd0, stall_o}, 0);
    step();
    set_id(3, 3, 7, 0, 0, 0, 0, AluOr, 4'b1000);
    #1;
    chk("raw.stall1", {31'd0, stall_o}, 1);
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("raw.bubble1", {28'd0, ex_ctrl_o}, 0);
    set_em(3, 1, 12);
    #1;
    chk("raw.stall2", {31'd0, stall_o}, 1);
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("raw.cnt", {16'd0, bubble_cnt_o}, {16'd0, exp_cnt});
    set_em(0, 0, 0);
    set_wb(3, 1, 42);
    id_rs1_data_i = 42;
    id_rs2_data_i = 42;
    #1;
    chk("raw.stall3", {31'd0, stall_o}, 0);
    step();
    chk("raw.data1", data1_o, 42);
    chk("raw.data2", data2_o, 42);
    chk("raw.aluctrl", {28'd0, ALUCtrl_o}, {28'd0, AluOr});
    chk("raw.rd", {27'd0, ex_rd_o}, 7);
    set_wb(0, 0, 0);
`endif

    // Flush coinciding with a load-use hazard: bubble, no stall, no count.
    set_id(1, 0, 5, 5, 0, 4, 1, AluAdd, 4'b1101);
    step();
    set_id(5, 1, 6, 0, 5, 0, 0, AluAdd, 4'b1000);
    flush_i = 1'b1;
    #1;
    chk("flush.stall", {31'd0, stall_o}, 0);
    step();
    flush_i = 1'b0;
    chk("flush.ctrl", {28'd0, ex_ctrl_o}, 0);
    chk("flush.cnt", {16'd0, bubble_cnt_o}, {16'd0, exp_cnt});

    // Load into x0 never stalls its consumer.
    set_id(1, 0, 0, 5, 0, 4, 1, AluAdd, 4'b1101);
    step();
    set_id(0, 0, 6, 0, 0, 0, 0, AluAdd, 4'b1000);
    #1;
    chk("x0.stall", {31'd0, stall_o}, 0);
    step();
    chk("x0.ctrl", {28'd0, ex_ctrl_o}, 4'b1000);

`ifndef ID_EX_FWD_EN
    // Continuous MEM hazard to drive the counter into saturation.
    set_id(3, 3, 6, 0, 0, 0, 0, AluAdd, 4'b1000);
    set_em(3, 1, 0);
    #1;
    chk("sat.stall", {31'd0, stall_o}, 1);
    repeat (int'(16'hFFFE - exp_cnt)) step();
    chk("sat.fffe", {16'd0, bubble_cnt_o}, 32'h0000FFFE);
    step();
    chk("sat.ffff", {16'd0, bubble_cnt_o}, 32'h0000FFFF);
    repeat (3) step();
    chk("sat.hold", {16'd0, bubble_cnt_o}, 32'h0000FFFF);
`else
    set_id(1, 0, 5, 5, 0, 4, 1, AluAdd, 4'b1101);
    step();
    set_id(5, 1, 6, 0, 5, 0, 0, AluAdd, 4'b1000);
`endif
    #1;
    chk("rstmid.pre_stall", {31'd0, stall_o}, 1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("rstmid.stall", {31'd0, stall_o}, 0);
    chk("rstmid.ctrl", {28'd0, ex_ctrl_o}, 0);
    chk("rstmid.rd", {27'd0, ex_rd_o}, 0);
    chk("rstmid.aluctrl", {28'd0, ALUCtrl_o}, 0);
    chk("rstmid.data1", data1_o, 0);
    chk("rstmid.data2", data2_o, 0);
    chk("rstmid.store", store_data_o, 0);
    chk("rstmid.cnt", {16'd0, bubble_cnt_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
